// File: rtl/alu_seq_top.sv
// Switch/button ALU: three debounced buttons load A, B and OP from the switches; one EXEC cycle registers result and flags.
// Press-to-output latency is DEBOUNCE_CYCLES+4 edges; a load arriving during EXEC extends EXEC by one cycle.
module alu_seq_top #(
  parameter int N_DATA          = 8,
  parameter int N_OP            = 6,
  parameter int N_B             = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_DATA-1:0] i_SWs,
  input  logic [N_B-1:0]    i_buttons,
  output logic [N_DATA-1:0] o_led,
  output logic              o_zero,
  output logic              o_carry,
  output logic              o_valid,
  output logic              o_err
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [5:0] OP6_ADD = 6'b100000;
  localparam logic [5:0] OP6_SUB = 6'b100010;
  localparam logic [5:0] OP6_AND = 6'b100100;
  localparam logic [5:0] OP6_OR  = 6'b100101;
  localparam logic [5:0] OP6_XOR = 6'b100110;
  localparam logic [5:0] OP6_NOR = 6'b100111;
  localparam logic [5:0] OP6_SRL = 6'b000010;
  localparam logic [5:0] OP6_SRA = 6'b000011;

  localparam logic [N_OP-1:0] C_ADD = OP6_ADD[N_OP-1:0];
  localparam logic [N_OP-1:0] C_SUB = OP6_SUB[N_OP-1:0];
  localparam logic [N_OP-1:0] C_AND = OP6_AND[N_OP-1:0];
  localparam logic [N_OP-1:0] C_OR  = OP6_OR[N_OP-1:0];
  localparam logic [N_OP-1:0] C_XOR = OP6_XOR[N_OP-1:0];
  localparam logic [N_OP-1:0] C_NOR = OP6_NOR[N_OP-1:0];
  localparam logic [N_OP-1:0] C_SRL = OP6_SRL[N_OP-1:0];
  localparam logic [N_OP-1:0] C_SRA = OP6_SRA[N_OP-1:0];

  typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

  logic [N_B-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N_B-1:0]    filt_q, filt_d, filt_prev_q, filt_prev_d;
  logic [CW-1:0]     cnt_q [N_B];
  logic [CW-1:0]     cnt_d [N_B];
  logic [N_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [N_OP-1:0]   op_q, op_d;
  logic [N_B-1:0]    mask_q, mask_d;
  state_t            state_q, state_d;
  logic [N_DATA-1:0] led_q, led_d;
  logic              zero_q, zero_d, carry_q, carry_d, valid_q, valid_d, err_q, err_d;

  logic [N_B-1:0]    pulse;
  logic              multi, single;
  logic [N_DATA:0]   sum;
  logic [N_DATA-1:0] alu_res;
  logic              alu_carry, alu_ill;

  assign pulse  = filt_q & ~filt_prev_q;
  assign multi  = |(pulse & (pulse - N_B'(1)));
  assign single = (pulse != '0) && !multi;
  assign sum    = {1'b0, a_q} + {1'b0, b_q};

  // Counter restarts whenever the synchronised level agrees with the filtered one.
  always_comb begin
    sync1_d     = i_buttons;
    sync2_d     = sync1_q;
    filt_d      = filt_q;
    filt_prev_d = filt_q;
    for (int i = 0; i < N_B; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) filt_d[i] = ~filt_q[i];
        else                      cnt_d[i]  = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ill   = 1'b0;
    case (op_q)
      C_ADD: {alu_carry, alu_res} = sum;
      C_SUB: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
      C_AND: alu_res = a_q & b_q;
      C_OR:  alu_res = a_q | b_q;
      C_XOR: alu_res = a_q ^ b_q;
      C_NOR: alu_res = ~(a_q | b_q);
      C_SRL: alu_res = a_q >> b_q;
      C_SRA: alu_res = $unsigned($signed(a_q) >>> b_q);
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    mask_d  = mask_q;
    state_d = state_q;
    led_d   = led_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (single) begin
      if (pulse[2]) a_d  = i_SWs;
      if (pulse[1]) b_d  = i_SWs;
      if (pulse[0]) op_d = i_SWs[N_OP-1:0];
      mask_d = mask_q | pulse;
    end
    case (state_q)
      S_IDLE: begin
        if (single) state_d = S_EXEC;
        if (multi)  err_d   = 1'b1;
      end
      S_EXEC: begin
        led_d   = alu_res;
        zero_d  = (alu_res == '0);
        carry_d = alu_carry;
        valid_d = &mask_q;
        err_d   = alu_ill | multi;
        state_d = single ? S_EXEC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      for (int i = 0; i < N_B; i++) cnt_q[i] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      mask_q  <= '0;
      state_q <= S_IDLE;
      led_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      for (int i = 0; i < N_B; i++) cnt_q[i] <= cnt_d[i];
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      led_q   <= led_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_led   = led_q;
  assign o_zero  = zero_q;
  assign o_carry = carry_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_alu_seq_top.sv
// Scoreboard bench for alu_seq_top: expected outputs are queued with the edge they must appear on.
module tb_alu_seq_top;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sws;
  logic [2:0] btn;
  logic [7:0] led;
  logic       zero, carry, valid, err;

  alu_seq_top #(.N_DATA(8), .N_OP(6), .N_B(3), .DEBOUNCE_CYCLES(D)) dut (
    .clock(clk), .reset(rst), .i_SWs(sws), .i_buttons(btn),
    .o_led(led), .o_zero(zero), .o_carry(carry), .o_valid(valid), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] led;
    logic       z, c, v, e;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  exp_t m_last;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  logic [7:0] m_a, m_b;
  logic [5:0] m_op;
  logic [2:0] m_mask;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, want);
    end
  endtask

  function automatic void alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                              output logic [7:0] r, output logic c, output logic e);
    r = 8'h00; c = 1'b0; e = 1'b0;
    case (op)
      6'h20: {c, r} = {1'b0, a} + {1'b0, b};
      6'h22: begin r = a - b; c = (a < b); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h02: r = (b >= 8'd8) ? 8'h00 : (a >> b);
      6'h03: begin
        if (b >= 8'd8) r = {8{a[7]}};
        else begin
          r = a;
          for (int i = 0; i < int'(b); i++) r = {a[7], r[7:1]};
        end
      end
      default: e = 1'b1;
    endcase
  endfunction

  function automatic exp_t model_load(input int at);
    exp_t x;
    alu(m_a, m_b, m_op, x.led, x.c, x.e);
    x.z   = (x.led == 8'h00);
    x.v   = (m_mask == 3'b111);
    x.cyc = at;
    return x;
  endfunction

  // Every cycle the outputs must equal the most recent expectation whose edge has passed.
  always @(negedge clk) begin
    if (chk_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) cur = sb.pop_front();
      check_val("outputs", {20'd0, led, zero, carry, valid, err},
                {20'd0, cur.led, cur.z, cur.c, cur.v, cur.e});
    end
  end

  task automatic press(input logic [2:0] b, input logic [7:0] sw, input int hold);
    exp_t x;
    int   t0;
    @(negedge clk);
    sws = sw;
    btn = b;
    t0  = cyc;
    if (b == 3'b100 || b == 3'b010 || b == 3'b001) begin
      if (b[2]) m_a  = sw;
      if (b[1]) m_b  = sw;
      if (b[0]) m_op = sw[5:0];
      m_mask = m_mask | b;
      x = model_load(t0 + 4 + D);
    end else begin
      x     = m_last;
      x.e   = 1'b1;
      x.cyc = t0 + 3 + D;
    end
    m_last = x;
    sb.push_back(x);
    repeat (hold) @(negedge clk);
    btn = 3'b000;
    sws = 8'($urandom);
    repeat (D + 6) @(negedge clk);
  endtask

  logic [7:0] lg_ops [4];
  logic [7:0] lg_exp [4];
  exp_t       rx;
  int         t0, r0;

  initial begin
    lg_ops = '{8'h24, 8'h25, 8'h26, 8'h27};
    lg_exp = '{8'h00, 8'h81, 8'h81, 8'h7E};
    rst = 1'b1; sws = 8'h00; btn = 3'b000;
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_mask = 3'b000;
    m_last = '{cyc: 0, led: 8'h00, z: 1'b0, c: 1'b0, v: 1'b0, e: 1'b0};
    cur = m_last;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("reset_outputs", {20'd0, led, zero, carry, valid, err}, 32'd0);
    chk_en = 1'b1;

    press(3'b100, 8'h05, 10);
    check_val("valid_before_op", 32'(valid), 32'd0);
    press(3'b010, 8'h03, 10);
    check_val("valid_before_op_b", 32'(valid), 32'd0);
    press(3'b001, 8'h20, 10);
    check_val("add_led", 32'(led), 32'h08);
    check_val("add_flags", {29'd0, zero, carry, valid}, 32'b001);

    press(3'b100, 8'hFF, 10);
    press(3'b010, 8'h01, 10);
    check_val("add_wrap_led", 32'(led), 32'h00);
    check_val("add_wrap_flags", {29'd0, zero, carry, err}, 32'b110);

    press(3'b001, 8'h22, 10);
    press(3'b100, 8'h01, 10);
    press(3'b010, 8'h02, 10);
    check_val("sub_led", 32'(led), 32'hFF);
    check_val("sub_borrow", 32'(carry), 32'd1);

    press(3'b001, 8'h03, 10);
    press(3'b100, 8'h80, 10);
    press(3'b010, 8'h03, 10);
    check_val("sra_3", 32'(led), 32'hF0);
    press(3'b010, 8'h09, 10);
    check_val("sra_9", 32'(led), 32'hFF);
    press(3'b001, 8'h02, 10);
    check_val("srl_9", 32'(led), 32'h00);
    check_val("srl_9_zero", 32'(zero), 32'd1);

    // Bounce B for 20 cycles, then hold; only the stable level may load.
    @(negedge clk);
    sws = 8'h01;
    for (int i = 0; i < 10; i++) begin
      btn[1] = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    press(3'b010, 8'h01, 10);
    check_val("bounce_srl_1", 32'(led), 32'h40);

    press(3'b110, 8'h55, 10);
    check_val("multi_err", 32'(err), 32'd1);
    press(3'b001, 8'h20, 10);
    check_val("multi_ab_kept", 32'(led), 32'h81);
    check_val("err_cleared", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      press(3'b001, lg_ops[i], 10);
      check_val("logic_op", 32'(led), 32'(lg_exp[i]));
    end
    press(3'b001, 8'h3F, 10);
    check_val("illegal_led", 32'(led), 32'h00);
    check_val("illegal_err", 32'(err), 32'd1);

    // Reset lands on the EXEC edge while A is still held.
    @(negedge clk);
    sws = 8'h11;
    btn = 3'b100;
    t0  = cyc;
    repeat (3 + D) @(negedge clk);
    rst = 1'b1;
    rx  = '{cyc: t0 + 4 + D, led: 8'h00, z: 1'b0, c: 1'b0, v: 1'b0, e: 1'b0};
    sb.push_back(rx);
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_mask = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_exec_outputs", {20'd0, led, zero, carry, valid, err}, 32'd0);
    r0 = cyc;
    m_a    = 8'h11;
    m_mask = 3'b100;
    m_last = model_load(r0 + 4 + D);
    sb.push_back(m_last);
    repeat (D + 2) @(negedge clk);
    check_val("no_early_load", 32'(err), 32'd0);
    repeat (6) @(negedge clk);
    btn = 3'b000;
    repeat (D + 6) @(negedge clk);
    check_val("reload_after_rst_err", 32'(err), 32'd1);
    check_val("reload_after_rst_valid", 32'(valid), 32'd0);

    check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_top.md
# alu_seq_top

Parametrised successor to the switch/button ALU top. Operands A and B and the opcode are loaded from the slide switches by three buttons. Each button is synchronised and debounced, and loads only on a clean rising edge. The block drives a registered result with zero/carry flags, a valid flag and an error flag onto the board LEDs. It sits directly under the board top-level, between the raw switch/button pins and the LEDs.

## Interface
- N_DATA, 8, operand/result width; also the i_SWs width
- N_OP, 6, opcode width; must satisfy N_OP <= N_DATA
- N_B, 3, button count; fixed at 3 for this generation
- DEBOUNCE_CYCLES, 4, consecutive stable samples required before the filtered button level changes; must be >= 1
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- i_SWs  in  N_DATA  switch data; asynchronous to clock, sampled only on a load pulse
- i_buttons  in  N_B  raw buttons: [2] loads A, [1] loads B, [0] loads OP
- o_led  out  N_DATA  registered ALU result
- o_zero  out  1  registered; high when the result is 0
- o_carry  out  1  registered carry-out for ADD, borrow for SUB; 0 for every other op
- o_valid  out  1  high once A, B and OP have each been loaded at least once since reset
- o_err  out  1  sticky error flag

## Operation
- Per-button front end:
  - 2-flop synchroniser.
  - Debounce counter: the synchronised level must differ from the filtered level for DEBOUNCE_CYCLES consecutive cycles before the filtered level takes the new value. Any bounce back resets the counter.
  - A rising edge of the filtered level produces a 1-cycle load pulse.
- Load:
  - Exactly one pulse in a cycle: the matching register captures i_SWs. OP captures i_SWs[N_OP-1:0]. The matching bit of a 3-bit loaded mask is set.
  - Two or more pulses in the same cycle: no register changes and o_err is set.
- FSM states and transitions:
  - IDLE -> EXEC on any accepted load.
  - EXEC, 1 cycle: compute from the current A/B/OP and register o_led, o_zero and o_carry. o_valid takes (mask == 3'b111). -> IDLE.
  - A load pulse arriving while in EXEC is accepted. The FSM then stays in EXEC for another cycle.
- Opcodes (N_OP = 6 encoding; narrower N_OP uses the low bits). Arithmetic is unsigned modulo 2^N_DATA unless stated:
  - 100000 ADD: {carry, res} = A + B
  - 100010 SUB: res = A - B; carry = (A < B)
  - 100100 AND
  - 100101 OR
  - 100110 XOR
  - 100111 NOR
  - 000010 SRL: A >> B. Shift amount is the full B value; B >= N_DATA gives 0.
  - 000011 SRA: arithmetic A >>> B. B >= N_DATA gives all bits equal to A[N_DATA-1].
  - Any other code: res = 0, carry = 0, o_err is set.
- o_err is sticky. It clears only on the next accepted single load that does not itself set it (a legal opcode) or on reset.
- Reset clears everything: A, B and OP = 0; mask = 0; filtered levels and counters = 0; FSM = IDLE; o_led = 0; o_zero = 0; o_carry = 0; o_valid = 0; o_err = 0.
- Reset mid-operation (during debounce or in EXEC) aborts it. No load occurs, and a button still held after reset needs a full debounce before it loads.

## Timing
- Button high from edge t0 onward:
  - synchroniser output high at edge t0+2
  - filtered level high at edge t0+2+DEBOUNCE_CYCLES
  - load pulse during the following cycle, so the register loads at edge t0+3+DEBOUNCE_CYCLES
  - o_led, o_zero, o_carry, o_valid and o_err update at edge t0+4+DEBOUNCE_CYCLES
- Release requires the same debounce. A held button produces exactly one load.
- Outputs are stable between EXEC cycles. Changing i_SWs alone never changes any output.

## Test plan
- Reset, then press A with SWs = 0x05, B with 0x03, OP with 0x20, each held 10 cycles -> o_led = 0x08, o_carry = 0, o_zero = 0. o_valid goes high only after the OP load, exactly DEBOUNCE_CYCLES+4 edges after the OP press.
- A = 0xFF, B = 0x01, ADD -> o_led = 0x00, o_carry = 1, o_zero = 1. Then SUB with A = 0x01, B = 0x02 -> o_led = 0xFF, o_carry = 1.
- SRA with A = 0x80, B = 3 -> 0xF0. B = 9 -> 0xFF. SRL with A = 0x80, B = 9 -> 0x00.
- Button bouncing 0/1 every 2 cycles for 20 cycles, then stable high (DEBOUNCE_CYCLES = 4) -> exactly one load, timed from the start of the stable level.
- Buttons A and B pressed in the same cycle -> A and B unchanged, o_err = 1. A subsequent single legal load -> o_err = 0. OP = 0x3F -> o_led = 0, o_err = 1.
- Assert reset during EXEC and while a button is held -> all outputs 0 on the next edge. No load until the held button is re-debounced after reset deasserts.
